hex_display_scanner: RTL and testbench

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/hex_seg_decoder.sv | 12 +
 rtl/hex_display_scanner.sv | 172 +++++++++++++++++
 tb/tb_hex_display_scanner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Seven-segment code constants and the nibble decode.
// Codes are abcdefg, bit 0 = g; dp is appended outside.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nib
  );
    logic [6:0] s;
    unique case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to abcdefg decoder.
// Thin wrapper so the top muxes one nibble into one decoder.
module hex_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner with frame-synced
// double buffering, zero blanking and dead time.
module hex_display_scanner
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter int DEAD           = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic                  lz_en,
  output logic [7:0]            abcdefgh,
  output logic [N_DIGITS-1:0]   digit,
  output logic                  frame_done
);

  localparam int NW = 4 * N_DIGITS;
  localparam int CW = $clog2(DIV);
  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam bit HAS_DEAD = (DEAD > 0);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                fd_q, fd_d;
  logic [NW-1:0]       pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_lz_q, pend_lz_d;
  logic                pend_valid_q, pend_valid_d;
  logic [NW-1:0]       act_val_q, act_val_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                act_lz_q, act_lz_d;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          dec_seg;
  logic [N_DIGITS-1:0] blank;
  logic                zero_above;

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  // Prescaler, digit index and frame pulse.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    fd_d = wrap;
  end

  // Pending/active buffers; active only changes on wrap.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_lz_d    = pend_lz_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_lz_d     = act_lz_q;
    if (load && wrap) begin
      act_val_d    = value;
      act_dp_d     = dp;
      act_lz_d     = lz_en;
      pend_valid_d = 1'b0;
    end else begin
      if (wrap && pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        act_lz_d     = pend_lz_q;
        pend_valid_d = 1'b0;
      end
      if (load) begin
        pend_val_d   = value;
        pend_dp_d    = dp;
        pend_lz_d    = lz_en;
        pend_valid_d = 1'b1;
      end
    end
  end

  // Blank digits whose nibble and all above are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above &&
        (act_val_q[4*i +: 4] == 4'h0);
      blank[i] = act_lz_q && (i > 0) && zero_above;
    end
  end

  // Select the nibble, dp and blank of the current slot.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = act_val_q[4*i +: 4];
        cur_dp    = act_dp_q[i];
        cur_blank = blank[i];
      end
    end
  end

  hex_seg_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Next pin image: segments and dead-timed digit.
  always_comb begin
    seg_d = cur_blank ? 8'h00 : {dec_seg, cur_dp};
    dig_d = '0;
    if (!(HAS_DEAD && (cnt_q < CW'(DEAD)))) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        dig_d[i] = (idx_q == IW'(i));
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      fd_q         <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_lz_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_lz_q     <= 1'b0;
      seg_q        <= '0;
      dig_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      fd_q         <= fd_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_lz_q    <= pend_lz_d;
      pend_valid_q <= pend_valid_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_lz_q     <= act_lz_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
    end
  end

  assign abcdefgh   = seg_q ^ {8{SEG_ACTIVE_LOW}};
  assign digit      = dig_q ^ {N_DIGITS{DIG_ACTIVE_LOW}};
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner.
// Second instance runs with active-low segments.
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg, seg_b;
  logic [3:0]  dig, dig_b;
  logic        fd, fd_b;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_cnt, pin_cnt;
  logic [1:0] m_idx, pin_idx;
  logic       pin_valid;

  hex_display_scanner #(
    .N_DIGITS(4), .DIV(8), .DEAD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .value(value), .dp(dp), .lz_en(lz_en),
    .abcdefgh(seg), .digit(dig),
    .frame_done(fd)
  );

  hex_display_scanner #(
    .N_DIGITS(4), .DIV(8), .DEAD(1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk(clk), .rst_n(rst_n), .load(load),
    .value(value), .dp(dp), .lz_en(lz_en),
    .abcdefgh(seg_b), .digit(dig_b),
    .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  // Timing model: m_* is the slot about to be clocked,
  // pin_* is the slot the registered pins now show.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= '0;
      m_idx     <= '0;
      pin_cnt   <= '0;
      pin_idx   <= '0;
      pin_valid <= 1'b0;
    end else begin
      pin_cnt   <= m_cnt;
      pin_idx   <= m_idx;
      pin_valid <= 1'b1;
      m_cnt     <= m_cnt + 3'd1;
      if (m_cnt == 3'd7) m_idx <= m_idx + 2'd1;
    end
  end

  task automatic wait_pin(input int i, input int c);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = pin_valid && (pin_idx == i) &&
           (pin_cnt == c);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_pin timeout idx=%0d cnt=%0d",
               i, c);
    end
  endtask

  task automatic load_at(
    input int i, input int c,
    input logic [15:0] v, input logic [3:0] d,
    input logic lz
  );
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = (m_idx == i) && (m_cnt == c);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL load_at timeout idx=%0d cnt=%0d",
               i, c);
    end
    load  = 1'b1;
    value = v;
    dp    = d;
    lz_en = lz;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (seg !== 8'h00 || dig !== 4'h0 || fd !== 1'b0)
      begin
      errors++;
      $display("FAIL reset_hold got %h %b %b want 00 0000 0",
               seg, dig, fd);
    end
    checks++;
    if (seg_b !== 8'hFF || dig_b !== 4'h0) begin
      errors++;
      $display("FAIL reset_low got %h %b want ff 0000",
               seg_b, dig_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_pin(0, 0);
    checks++;
    if (dig !== 4'b0000 || seg !== 8'hFC) begin
      errors++;
      $display("FAIL first_slot got %h %b want fc 0000",
               seg, dig);
    end
    wait_pin(0, 1);
    checks++;
    if (dig !== 4'b0001) begin
      errors++;
      $display("FAIL first_digit got %b want 0001", dig);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [4];
    exp = '{8'h8E, 8'hEE, 8'hDB, 8'h60};
    load_at(1, 2, 16'h12AF, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_pin(k, 4);
      checks++;
      if (seg !== exp[k] || dig !== 4'(1 << k)) begin
        errors++;
        $display("FAIL basic d%0d got %h %b want %h %b",
                 k, seg, dig, exp[k], 4'(1 << k));
      end
      if (k == 0) begin
        checks++;
        if (seg_b !== 8'h71 || dig_b !== 4'b0001) begin
          errors++;
          $display("FAIL basic_low got %h %b want 71 0001",
                   seg_b, dig_b);
        end
      end
    end
  endtask

  task automatic test_midframe();
    logic [7:0] exp [4];
    exp = '{8'hBE, 8'hB6, 8'h66, 8'hF2};
    load_at(2, 3, 16'h3456, 4'b0000, 1'b0);
    checks++;
    if (dut.pend_valid_q !== 1'b1) begin
      errors++;
      $display("FAIL mid_pend got %b want 1",
               dut.pend_valid_q);
    end
    wait_pin(2, 5);
    checks++;
    if (seg !== 8'hDB) begin
      errors++;
      $display("FAIL mid_old2 got %h want db", seg);
    end
    wait_pin(3, 4);
    checks++;
    if (seg !== 8'h60) begin
      errors++;
      $display("FAIL mid_old3 got %h want 60", seg);
    end
    for (int k = 0; k < 4; k++) begin
      wait_pin(k, 4);
      checks++;
      if (seg !== exp[k]) begin
        errors++;
        $display("FAIL mid_new d%0d got %h want %h",
                 k, seg, exp[k]);
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] e1 [4];
    logic [7:0] e0 [4];
    e1 = '{8'hB6, 8'h00, 8'h00, 8'h00};
    e0 = '{8'hB6, 8'hFC, 8'hFC, 8'hFC};
    load_at(1, 2, 16'h0005, 4'b0010, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_pin(k, 4);
      checks++;
      if (seg !== e1[k] || dig !== 4'(1 << k)) begin
        errors++;
        $display("FAIL lz_on d%0d got %h %b want %h",
                 k, seg, dig, e1[k]);
      end
    end
    load_at(1, 2, 16'h0005, 4'b0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_pin(k, 4);
      checks++;
      if (seg !== e0[k]) begin
        errors++;
        $display("FAIL lz_off d%0d got %h want %h",
                 k, seg, e0[k]);
      end
    end
  endtask

  task automatic test_wrap_load();
    logic [7:0] exp [4];
    exp = '{8'h7A, 8'hFC, 8'h9C, 8'hFD};
    load_at(3, 7, 16'h0C0D, 4'b1000, 1'b0);
    checks++;
    if (dut.pend_valid_q !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pend got %b want 0",
               dut.pend_valid_q);
    end
    for (int k = 0; k < 4; k++) begin
      wait_pin(k, 4);
      checks++;
      if (seg !== exp[k]) begin
        errors++;
        $display("FAIL wrap_load d%0d got %h want %h",
                 k, seg, exp[k]);
      end
    end
  endtask

  task automatic test_dead();
    int pulses;
    logic exp_fd;
    pulses = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      exp_fd = (m_cnt == 3'd0) && (m_idx == 2'd0);
      if (fd === 1'b1) pulses++;
      checks++;
      if (fd !== exp_fd) begin
        errors++;
        $display("FAIL frame_done n=%0d got %b want %b",
                 n, fd, exp_fd);
      end
      if (pin_cnt == 3'd0) begin
        checks++;
        if (dig !== 4'b0000) begin
          errors++;
          $display("FAIL dead slot%0d got %b want 0000",
                   pin_idx, dig);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL frame_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    load_at(1, 2, 16'h9999, 4'b1111, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_b !== 8'hFF || dig_b !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_low got %h %b want ff 0000",
               seg_b, dig_b);
    end
    checks++;
    if (seg !== 8'h00 || dig !== 4'h0 || fd !== 1'b0)
      begin
      errors++;
      $display("FAIL rst_mid got %h %b %b want 00 0000 0",
               seg, dig, fd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        wait_pin(k, 4);
        checks++;
        if (seg !== 8'hFC || dig !== 4'(1 << k)) begin
          errors++;
          $display("FAIL rst_discard f%0d d%0d got %h %b",
                   f, k, seg, dig);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe();
    test_lz();
    test_wrap_load();
    test_dead();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
